// File: rtl/ex_issue_stage_if.sv
// Bundle for the EX issue stage: decode-side fields, pipeline control,
// forwarding taps and the stage outputs.
interface ex_issue_stage_if;
    // decode side
    logic        id_valid;
    logic [4:0]  id_ctrl;      // {reg_write, mem_read, mem_write, mem_to_reg, alu_src}
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_dest;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    // pipeline control
    logic        stall;
    logic        flush;
    // forwarding taps
    logic        mem_fwd_en;
    logic [4:0]  mem_fwd_rd;
    logic [31:0] mem_fwd_data;
    logic        wb_fwd_en;
    logic [4:0]  wb_fwd_rd;
    logic [31:0] wb_fwd_data;
    // stage outputs
    logic        ex_valid;
    logic [3:0]  ex_ctrl;      // {reg_write, mem_read, mem_write, mem_to_reg}
    logic [4:0]  ex_dest;
    logic [31:0] alu_input1;
    logic [31:0] alu_input2;
    logic [3:0]  alu_sel;
    logic [31:0] ex_store_data;
    logic        hazard_stall;

    modport master (
        output id_valid, id_ctrl, id_alu_op, id_funct, id_rs, id_rt, id_dest,
               id_rs_data, id_rt_data, id_imm, stall, flush,
               mem_fwd_en, mem_fwd_rd, mem_fwd_data,
               wb_fwd_en, wb_fwd_rd, wb_fwd_data,
        input  ex_valid, ex_ctrl, ex_dest, alu_input1, alu_input2, alu_sel,
               ex_store_data, hazard_stall
    );

    modport slave (
        input  id_valid, id_ctrl, id_alu_op, id_funct, id_rs, id_rt, id_dest,
               id_rs_data, id_rt_data, id_imm, stall, flush,
               mem_fwd_en, mem_fwd_rd, mem_fwd_data,
               wb_fwd_en, wb_fwd_rd, wb_fwd_data,
        output ex_valid, ex_ctrl, ex_dest, alu_input1, alu_input2, alu_sel,
               ex_store_data, hazard_stall
    );
endinterface

// File: rtl/ex_issue_stage.sv
// EX issue stage: ID/EX pipeline register with ALU-select decode at capture,
// zero-latency MEM/WB operand forwarding and load-use hazard detection.
module ex_issue_stage (
    input  logic              clk,
    input  logic              rst_n,
    ex_issue_stage_if.slave   bus
);

    typedef struct packed {
        logic        valid;
        logic [3:0]  ctrl;     // {reg_write, mem_read, mem_write, mem_to_reg}
        logic        alu_src;
        logic [3:0]  alu_sel;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
    } ex_reg_t;

    ex_reg_t     ex_q, ex_d;
    logic        hazard;
    logic [31:0] fwd_a, fwd_b;

    // ALU class + funct -> ALU selection lines; unknown R-type funct falls back to add
    function automatic logic [3:0] alu_decode(input logic [1:0] op, input logic [5:0] funct);
        logic [3:0] sel;
        sel = 4'b0010;
        case (op)
            2'b00: sel = 4'b0010;
            2'b01: sel = 4'b0110;
            2'b11: sel = 4'b0001;
            default: begin
                case (funct)
                    6'b100000: sel = 4'b0010;
                    6'b100010: sel = 4'b0110;
                    6'b100100: sel = 4'b0000;
                    6'b100101: sel = 4'b0001;
                    6'b101010: sel = 4'b0111;
                    default:   sel = 4'b0010;
                endcase
            end
        endcase
        return sel;
    endfunction

    // Newest producer wins (MEM over WB); r0 is hard-wired zero so never forwards
    function automatic logic [31:0] fwd_pick(
        input logic [4:0]  src,
        input logic [31:0] reg_val,
        input logic        m_en,
        input logic [4:0]  m_rd,
        input logic [31:0] m_data,
        input logic        w_en,
        input logic [4:0]  w_rd,
        input logic [31:0] w_data
    );
        logic [31:0] val;
        val = reg_val;
        if (m_en && (m_rd != 5'd0) && (m_rd == src))
            val = m_data;
        else if (w_en && (w_rd != 5'd0) && (w_rd == src))
            val = w_data;
        return val;
    endfunction

    // Load-use hazard: a load in EX feeding the instruction sitting in decode
    always_comb begin
        hazard = ex_q.valid && ex_q.ctrl[2] && (ex_q.dest != 5'd0) &&
                 ((ex_q.dest == bus.id_rs) || (ex_q.dest == bus.id_rt)) && bus.id_valid;
    end

    // Next stage contents: flush > stall > load-use bubble > load
    always_comb begin
        ex_d = ex_q;
        if (bus.flush) begin
            ex_d.valid = 1'b0;
            ex_d.ctrl  = 4'd0;
        end else if (bus.stall) begin
            ex_d = ex_q;
        end else if (hazard) begin
            // decode holds its inputs, so the dependent op loads next edge
            ex_d.valid = 1'b0;
            ex_d.ctrl  = 4'd0;
        end else begin
            ex_d.valid   = bus.id_valid;
            ex_d.ctrl    = bus.id_valid ? bus.id_ctrl[4:1] : 4'd0;
            ex_d.alu_src = bus.id_ctrl[0];
            ex_d.alu_sel = alu_decode(bus.id_alu_op, bus.id_funct);
            ex_d.rs      = bus.id_rs;
            ex_d.rt      = bus.id_rt;
            ex_d.dest    = bus.id_dest;
            ex_d.rs_data = bus.id_rs_data;
            ex_d.rt_data = bus.id_rt_data;
            ex_d.imm     = bus.id_imm;
        end
    end

    // Stage register; reset discards whatever is held, including stalled ops
    always_ff @(posedge clk) begin
        if (!rst_n)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    // Operand forwarding against the registered source numbers
    always_comb begin
        fwd_a = fwd_pick(ex_q.rs, ex_q.rs_data,
                         bus.mem_fwd_en, bus.mem_fwd_rd, bus.mem_fwd_data,
                         bus.wb_fwd_en, bus.wb_fwd_rd, bus.wb_fwd_data);
        fwd_b = fwd_pick(ex_q.rt, ex_q.rt_data,
                         bus.mem_fwd_en, bus.mem_fwd_rd, bus.mem_fwd_data,
                         bus.wb_fwd_en, bus.wb_fwd_rd, bus.wb_fwd_data);
    end

    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_ctrl       = ex_q.ctrl;
    assign bus.ex_dest       = ex_q.dest;
    assign bus.alu_sel       = ex_q.alu_sel;
    assign bus.alu_input1    = fwd_a;
    assign bus.alu_input2    = ex_q.alu_src ? ex_q.imm : fwd_b;
    assign bus.ex_store_data = fwd_b;
    assign bus.hazard_stall  = hazard;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Scoreboard bench for ex_issue_stage: the stimulus process drives one cycle
// of inputs and pushes the hand-computed visible outputs for that cycle; the
// monitor pops and compares on the falling edge.
module tb_ex_issue_stage;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ex_issue_stage_if bus ();

    ex_issue_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [95:0] name;
        logic [7:0]  m;     // 0 vld,1 ctrl,2 dest,3 sel,4 a1,5 a2,6 sd,7 hz
        logic        vld;
        logic [3:0]  ctrl;
        logic [4:0]  dest;
        logic [3:0]  sel;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] sd;
        logic        hz;
    } exp_t;

    localparam logic [7:0] ALL = 8'hFF;
    localparam logic [7:0] VCH = 8'b1000_0011;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    function automatic exp_t mk(input logic [95:0] name, input logic [7:0] m,
                                input logic vld, input logic [3:0] ctrl,
                                input logic [4:0] dest, input logic [3:0] sel,
                                input logic [31:0] a1, input logic [31:0] a2,
                                input logic [31:0] sd, input logic hz);
        exp_t e;
        e.name = name; e.m = m; e.vld = vld; e.ctrl = ctrl; e.dest = dest;
        e.sel = sel; e.a1 = a1; e.a2 = a2; e.sd = sd; e.hz = hz;
        return e;
    endfunction

    task automatic cmp(input logic [95:0] nm, input string fld,
                       input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want)
            $display("FAIL %0s.%0s got %h exp %h", nm, fld, got, want);
        else
            n_pass++;
    endtask

    // Monitor: compare every pending expectation against the settled outputs
    always @(negedge clk) begin
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.m[0]) cmp(e.name, "ex_valid",   {31'd0, bus.ex_valid},     {31'd0, e.vld});
            if (e.m[1]) cmp(e.name, "ex_ctrl",    {28'd0, bus.ex_ctrl},      {28'd0, e.ctrl});
            if (e.m[2]) cmp(e.name, "ex_dest",    {27'd0, bus.ex_dest},      {27'd0, e.dest});
            if (e.m[3]) cmp(e.name, "alu_sel",    {28'd0, bus.alu_sel},      {28'd0, e.sel});
            if (e.m[4]) cmp(e.name, "alu_input1", bus.alu_input1,            e.a1);
            if (e.m[5]) cmp(e.name, "alu_input2", bus.alu_input2,            e.a2);
            if (e.m[6]) cmp(e.name, "store_data", bus.ex_store_data,         e.sd);
            if (e.m[7]) cmp(e.name, "hazard",     {31'd0, bus.hazard_stall}, {31'd0, e.hz});
        end
    end

    task automatic set_id(input logic v, input logic [4:0] ctrl, input logic [1:0] op,
                          input logic [5:0] funct, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] dest, input logic [31:0] rsd,
                          input logic [31:0] rtd, input logic [31:0] imm);
        bus.id_valid = v;   bus.id_ctrl = ctrl; bus.id_alu_op = op; bus.id_funct = funct;
        bus.id_rs = rs;     bus.id_rt = rt;     bus.id_dest = dest;
        bus.id_rs_data = rsd; bus.id_rt_data = rtd; bus.id_imm = imm;
    endtask

    task automatic set_fwd(input logic men, input logic [4:0] mrd, input logic [31:0] md,
                           input logic wen, input logic [4:0] wrd, input logic [31:0] wd);
        bus.mem_fwd_en = men; bus.mem_fwd_rd = mrd; bus.mem_fwd_data = md;
        bus.wb_fwd_en  = wen; bus.wb_fwd_rd  = wrd; bus.wb_fwd_data  = wd;
    endtask

    // Expectation covers this cycle (state from the last edge, comb from the
    // inputs just driven); the next edge then consumes those inputs.
    task automatic cyc(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        set_id(0, 5'd0, 2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        set_fwd(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        @(posedge clk);
        #1;

        cyc(mk("rst", ALL, 0, 4'h0, 5'd0, 4'h0, 0, 0, 0, 0));
        rst_n = 1'b1;
        // R-type add r3 = r1 + r2
        set_id(1, 5'b10000, 2'b10, 6'b100000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0);
        cyc(mk("rst_hold", ALL, 0, 4'h0, 5'd0, 4'h0, 0, 0, 0, 0));
        // R-type sub r5 = r3 - r4
        set_id(1, 5'b10000, 2'b10, 6'b100010, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'd0);
        cyc(mk("add", ALL, 1, 4'b1000, 5'd3, 4'b0010, 32'd5, 32'd7, 32'd7, 0));
        set_fwd(1, 5'd3, 32'hAA, 1, 5'd3, 32'hBB);
        cyc(mk("fwd_mem", ALL, 1, 4'b1000, 5'd5, 4'b0110, 32'hAA, 32'h22, 32'h22, 0));
        set_fwd(1, 5'd0, 32'hAA, 1, 5'd3, 32'hBB);
        cyc(mk("fwd_wb", ALL, 1, 4'b1000, 5'd5, 4'b0110, 32'hBB, 32'h22, 32'h22, 0));
        set_fwd(1, 5'd4, 32'hCC, 1, 5'd3, 32'hBB);
        cyc(mk("fwd_rt", ALL, 1, 4'b1000, 5'd5, 4'b0110, 32'hBB, 32'hCC, 32'hCC, 0));
        // OR-class op reading r0 twice, forward taps pointing at r0
        set_id(1, 5'b10000, 2'b11, 6'd0, 5'd0, 5'd0, 5'd9, 32'd1, 32'd2, 32'd0);
        set_fwd(1, 5'd0, 32'hDD, 1, 5'd0, 32'hEE);
        cyc(mk("fwd_none", ALL, 1, 4'b1000, 5'd5, 4'b0110, 32'h11, 32'h22, 32'h22, 0));
        // lw r8, 4(r1)
        set_id(1, 5'b11011, 2'b00, 6'd0, 5'd1, 5'd8, 5'd8, 32'h100, 32'd0, 32'd4);
        cyc(mk("r0_nofwd", ALL, 1, 4'b1000, 5'd9, 4'b0001, 32'd1, 32'd2, 32'd2, 0));
        // dependent add r10 = r8 + r2
        set_fwd(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        set_id(1, 5'b10000, 2'b10, 6'b100000, 5'd8, 5'd2, 5'd10, 32'h555, 32'd3, 32'd0);
        cyc(mk("lw_hz", ALL, 1, 4'b1101, 5'd8, 4'b0010, 32'h100, 32'd4, 32'd0, 1));
        cyc(mk("bubble", VCH, 0, 4'h0, 5'd0, 4'h0, 0, 0, 0, 0));
        // subtract-class with immediate
        set_id(1, 5'b10001, 2'b01, 6'd0, 5'd1, 5'd2, 5'd11, 32'h50, 32'h60, 32'hFFFF_FFFC);
        cyc(mk("dep_load", ALL, 1, 4'b1000, 5'd10, 4'b0010, 32'h555, 32'd3, 32'd3, 0));
        bus.stall = 1'b1;
        set_id(1, 5'b10000, 2'b10, 6'b100100, 5'd7, 5'd2, 5'd12, 32'h999, 32'd0, 32'd0);
        cyc(mk("subi", ALL, 1, 4'b1000, 5'd11, 4'b0110, 32'h50, 32'hFFFF_FFFC, 32'h60, 0));
        cyc(mk("stall1", ALL, 1, 4'b1000, 5'd11, 4'b0110, 32'h50, 32'hFFFF_FFFC, 32'h60, 0));
        cyc(mk("stall2", ALL, 1, 4'b1000, 5'd11, 4'b0110, 32'h50, 32'hFFFF_FFFC, 32'h60, 0));
        bus.flush = 1'b1;
        cyc(mk("stall3", ALL, 1, 4'b1000, 5'd11, 4'b0110, 32'h50, 32'hFFFF_FFFC, 32'h60, 0));
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        // sw r2, 8(r1)
        set_id(1, 5'b00101, 2'b00, 6'd0, 5'd1, 5'd2, 5'd0, 32'h200, 32'h77, 32'd8);
        cyc(mk("flush", VCH, 0, 4'h0, 5'd0, 4'h0, 0, 0, 0, 0));
        bus.stall = 1'b1;
        cyc(mk("sw", ALL, 1, 4'b0010, 5'd0, 4'b0010, 32'h200, 32'd8, 32'h77, 0));
        rst_n = 1'b0;
        cyc(mk("sw_held", ALL, 1, 4'b0010, 5'd0, 4'b0010, 32'h200, 32'd8, 32'h77, 0));
        rst_n = 1'b1;
        bus.stall = 1'b0;
        // lw r9, 0x20(r1)
        set_id(1, 5'b11011, 2'b00, 6'd0, 5'd1, 5'd9, 5'd9, 32'h10, 32'd0, 32'h20);
        cyc(mk("rst_mid", ALL, 0, 4'h0, 5'd0, 4'h0, 0, 0, 0, 0));
        // slt r13 = r2 < r9, held under stall while the hazard is visible
        bus.stall = 1'b1;
        set_id(1, 5'b10000, 2'b10, 6'b101010, 5'd2, 5'd9, 5'd13, 32'd1, 32'd2, 32'd0);
        cyc(mk("lw2", ALL, 1, 4'b1101, 5'd9, 4'b0010, 32'h10, 32'h20, 32'd0, 1));
        bus.stall = 1'b0;
        cyc(mk("hz_stall", ALL, 1, 4'b1101, 5'd9, 4'b0010, 32'h10, 32'h20, 32'd0, 1));
        cyc(mk("bubble2", VCH, 0, 4'h0, 5'd0, 4'h0, 0, 0, 0, 0));
        bus.id_valid = 1'b0;
        cyc(mk("slt", ALL, 1, 4'b1000, 5'd13, 4'b0111, 32'd1, 32'd2, 32'd2, 0));

        repeat (3) @(negedge clk);
        n_total++;
        if (exp_q.size() != 0)
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ex_issue_stage.md
EX_ISSUE_STAGE -- requirements
Module: ex_issue_stage

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset, with ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
REQ-002 The module SHALL have the following decode-side ports:
- id_valid  input  1  decode slot holds a real instruction.
- id_ctrl  input  5  {reg_write, mem_read, mem_write, mem_to_reg, alu_src}.
- id_alu_op  input  2  main-decoder ALU class.
- id_funct  input  6  R-type funct field.
- id_rs  input  5  source register A number.
- id_rt  input  5  source register B number.
- id_dest  input  5  destination register (rd/rt already selected).
- id_rs_data  input  32  register-file value of rs.
- id_rt_data  input  32  register-file value of rt.
- id_imm  input  32  sign-extended immediate.
REQ-003 The module SHALL have the following pipeline-control and forwarding ports:
- stall  input  1  downstream hold; stage keeps its contents.
- flush  input  1  branch/jump kill; stage becomes a bubble.
- mem_fwd_en, mem_fwd_rd, mem_fwd_data  input  1/5/32  MEM-stage writeback forward.
- wb_fwd_en, wb_fwd_rd, wb_fwd_data  input  1/5/32  WB-stage writeback forward.
REQ-004 The module SHALL have the following outputs:
- ex_valid  output  1  stage holds a real instruction.
- ex_ctrl  output  4  registered {reg_write, mem_read, mem_write, mem_to_reg}; zero when ex_valid is 0.
- ex_dest  output  5  registered destination register.
- alu_input1  output  32  ALU operand A.
- alu_input2  output  32  ALU operand B.
- alu_sel  output  4  ALU selection lines.
- ex_store_data  output  32  forwarded rt value, used for stores.
- hazard_stall  output  1  load-use stall request to the PC and decode stage.

Function
REQ-005 Edge priority per rising clk SHALL be: reset > flush > stall > load-use bubble > load.
- flush: clears ex_valid and ex_ctrl.
- stall: holds every register.
- bubble: as flush.
- load: captures all id_* fields, with ex_valid=id_valid.
REQ-006 alu_sel SHALL be computed from id_alu_op/id_funct at capture and then registered:
- alu_op 00: 0010 (add).
- alu_op 01: 0110 (sub).
- alu_op 11: 0001 (or).
- alu_op 10, by funct: 100000→0010, 100010→0110, 100100→0000, 100101→0001, 101010→0111; any other funct→0010.
REQ-007 Forwarded A SHALL be selected combinationally against the registered rs, in priority order:
- mem_fwd_data if mem_fwd_en && mem_fwd_rd!=0 && mem_fwd_rd==ex_rs;
- else wb_fwd_data under the same test on wb_fwd_*;
- else the registered rs_data.
Forwarded B SHALL be selected identically against the registered rt.
REQ-008 Operand outputs SHALL be driven as follows:
- alu_input1 = forwarded A.
- alu_input2 = registered alu_src ? registered imm : forwarded B.
- ex_store_data = forwarded B.
REQ-009 hazard_stall SHALL be combinational, equal to ex_valid && ex_ctrl.mem_read && ex_dest!=0 && (ex_dest==id_rs || ex_dest==id_rt) && id_valid.
REQ-010 When hazard_stall=1 and stall=0 at an edge, the stage SHALL load a bubble; the decode side holds its inputs, so the instruction is captured on the following edge.
REQ-011 Latency SHALL be one cycle from an id_* capture to the corresponding outputs; forwarding paths SHALL have zero latency.
REQ-012 Register 0 SHALL never be a forwarding or hazard match.
REQ-013 With stall and flush both asserted, flush SHALL win.
REQ-014 With stall=1, hazard_stall SHALL still be reported but no bubble is inserted.

Reset
REQ-015 While rst_n=0 at an edge, the stage SHALL clear every registered field: ex_valid=0, ex_ctrl=0, ex_dest=0, alu_sel=0000, data/imm/rs/rt=0.
REQ-016 Consequently, after reset hazard_stall=0 and alu_input1=alu_input2=ex_store_data=0 (absent forwarding matches).
REQ-017 Reset asserted mid-stall or mid-hazard SHALL discard the held instruction.

Verification
REQ-018 Load R-type add (alu_op 10, funct 100000), rs_data=5, rt_data=7, no forwarding → next cycle alu_input1=5, alu_input2=7, alu_sel=0010, ex_valid=1.
REQ-019 ex_rs=3 with mem_fwd_en=1, mem_fwd_rd=3, mem_fwd_data=0xAA and wb_fwd_en=1, wb_fwd_rd=3, wb_fwd_data=0xBB → alu_input1=0xAA. Repeat with mem_fwd_rd=0 → alu_input1=0xBB.
REQ-020 Load lw (mem_read=1, dest=8), then decode presents id_rs=8 → hazard_stall=1. The next edge yields ex_valid=0 and ex_ctrl=0. On the following edge the dependent instruction loads and hazard_stall=0.
REQ-021 alu_op 01 with alu_src=1, imm=0xFFFFFFFC → alu_sel=0110, alu_input2=0xFFFFFFFC. Assert stall=1 for 3 cycles → outputs unchanged. Then stall=1 and flush=1 together → ex_valid=0.
REQ-022 Assert rst_n=0 for one edge while a valid sw is held under stall → ex_valid=0, ex_ctrl=0, alu_sel=0000, hazard_stall=0.
